aes2_ctr_seq: RTL and testbench

CTR-mode sequencer that drives the serialized AES engine (`aes_cipher_top`, as wrapped by `aes2_sed`) from the initiator side. It accepts a key/IV configuration and a stream of 128-bit data blocks. For each block it presents the current counter block to the engine, issues a clean 0→1 start edge, and waits for the engine's done pulse. It then XORs the keystream with the data and returns the result on a valid/ready stream. Encryption and decryption are the same operation; the same IV must be used for both.

---
 rtl/aes2_pkg.sv | 15 +
 rtl/aes2_ctr_seq_if.sv | 50 +++++
 rtl/aes2_ctr_inc.sv | 18 +
 rtl/aes2_ctr_seq.sv | 127 ++++++++++++
 tb/tb_aes2_ctr_seq.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes2_pkg.sv
// Shared constants and types for the AES CTR sequencer.
package aes2_pkg;

  localparam int unsigned AES_BLK_W   = 128;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IN,
    ST_START,
    ST_WAIT_ENG,
    ST_OUT
  } aes2_ctr_state_t;

endpackage

// File: rtl/aes2_ctr_seq_if.sv
// Configuration, block stream, result stream and engine signals of the CTR sequencer.
interface aes2_ctr_seq_if;
  import aes2_pkg::*;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [AES_BLK_W-1:0] cfg_key;
  logic [AES_BLK_W-1:0] cfg_iv;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [AES_BLK_W-1:0] in_data;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [AES_BLK_W-1:0] out_data;

  logic                 eng_start;
  logic [AES_BLK_W-1:0] eng_key;
  logic [AES_BLK_W-1:0] eng_text;
  logic                 eng_done;
  logic [AES_BLK_W-1:0] eng_out;

  // Sequencer side
  modport slave (
    input  cfg_valid, cfg_key, cfg_iv,
    output cfg_ready,
    input  in_valid, in_data, in_last,
    output in_ready,
    output out_valid, out_data, out_last,
    input  out_ready,
    output eng_start, eng_key, eng_text,
    input  eng_done, eng_out
  );

  // Initiator / engine side
  modport master (
    output cfg_valid, cfg_key, cfg_iv,
    input  cfg_ready,
    output in_valid, in_data, in_last,
    input  in_ready,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  eng_start, eng_key, eng_text,
    output eng_done, eng_out
  );

endinterface

// File: rtl/aes2_ctr_inc.sv
// Counter-block increment: low CTR_W bits wrap, upper bits pass through untouched.
module aes2_ctr_inc
  import aes2_pkg::*;
#(
  parameter int unsigned CTR_W = 32
) (
  input  logic [AES_BLK_W-1:0] ctr_in,
  output logic [AES_BLK_W-1:0] ctr_out
);

  // Full-width counter needs no pass-through slice
  if (CTR_W >= AES_BLK_W) begin : g_full
    assign ctr_out = ctr_in + AES_BLK_W'(1);
  end else begin : g_part
    assign ctr_out = {ctr_in[AES_BLK_W-1:CTR_W], ctr_in[CTR_W-1:0] + CTR_W'(1)};
  end

endmodule

// File: rtl/aes2_ctr_seq.sv
// CTR-mode sequencer: feeds counter blocks to the AES engine and XORs the keystream with data.
module aes2_ctr_seq
  import aes2_pkg::*;
#(
  parameter int unsigned CTR_W   = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  aes2_ctr_seq_if.slave   bus,
  output logic            busy,
  output logic            err,
  output logic [15:0]     blk_cnt
);

  localparam int unsigned TO_W = $clog2(TIMEOUT);

  aes2_ctr_state_t state, state_nxt;

  logic [AES_BLK_W-1:0] key_q, ctr_q, ctr_inc, data_q, out_data_q;
  logic                 last_q, out_last_q;
  logic                 cfg_ready_q, in_ready_q, out_valid_q, eng_start_q;
  logic [TO_W-1:0]      tcnt;
  logic                 ld_cfg, ld_in, ld_res, out_ack, to_err, to_hit;

  aes2_ctr_inc #(.CTR_W(CTR_W)) u_inc (
    .ctr_in  (ctr_q),
    .ctr_out (ctr_inc)
  );

  assign to_hit = (tcnt == TO_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    ld_cfg    = 1'b0;
    ld_in     = 1'b0;
    ld_res    = 1'b0;
    out_ack   = 1'b0;
    to_err    = 1'b0;
    case (state)
      ST_IDLE: if (bus.cfg_valid) begin
        ld_cfg    = 1'b1;
        state_nxt = ST_WAIT_IN;
      end
      ST_WAIT_IN: if (bus.in_valid) begin
        ld_in     = 1'b1;
        state_nxt = ST_START;
      end
      ST_START: state_nxt = ST_WAIT_ENG;
      ST_WAIT_ENG: begin
        if (bus.eng_done) begin
          ld_res    = 1'b1;
          state_nxt = ST_OUT;
        end else if (to_hit) begin
          to_err    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_OUT: if (bus.out_ready) begin
        out_ack   = 1'b1;
        state_nxt = out_last_q ? ST_IDLE : ST_WAIT_IN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath, status and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q       <= '0;
      ctr_q       <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err         <= 1'b0;
      blk_cnt     <= '0;
      tcnt        <= '0;
      cfg_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      eng_start_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (ld_cfg) begin
        key_q   <= bus.cfg_key;
        ctr_q   <= bus.cfg_iv;
        err     <= 1'b0;
        blk_cnt <= '0;
      end
      if (ld_in) begin
        data_q <= bus.in_data;
        last_q <= bus.in_last;
      end
      if (ld_res) begin
        out_data_q <= bus.eng_out ^ data_q;
        out_last_q <= last_q;
        ctr_q      <= ctr_inc;
      end
      if (to_err)  err     <= 1'b1;
      if (out_ack) blk_cnt <= blk_cnt + 16'd1;
      tcnt        <= (state == ST_WAIT_ENG) ? tcnt + TO_W'(1) : '0;
      cfg_ready_q <= (state_nxt == ST_IDLE);
      in_ready_q  <= (state_nxt == ST_WAIT_IN);
      out_valid_q <= (state_nxt == ST_OUT);
      eng_start_q <= (state_nxt == ST_START);
      busy        <= (state_nxt != ST_IDLE);
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_key   = key_q;
  assign bus.eng_text  = ctr_q;

endmodule

// File: tb/tb_aes2_ctr_seq.sv
// Scoreboard bench for aes2_ctr_seq with a behavioural AES-128 engine stub.
module tb_aes2_ctr_seq;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy, err;
  logic [15:0] blk_cnt;

  aes2_ctr_seq_if ifc();

  aes2_ctr_seq #(.CTR_W(32), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (ifc),
    .busy    (busy),
    .err     (err),
    .blk_cnt (blk_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Scoreboard queues and logs
  logic [127:0] exp_d[$];
  logic         exp_l[$];
  logic [127:0] ctr_q[$];
  logic [127:0] got_q[$];
  logic [127:0] text_log[$];

  logic [127:0] m_key, m_ctr;
  bit           eng_en = 1'b1;
  bit           bp_hold = 1'b0;

  task automatic chk_w(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // ---------------- behavioural AES-128 ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, xv;
      xv  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (xv != 8'h00 && gmul(xv, 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s[16], k[16], t[16], rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8];
      k[i] = key[127-8*i -: 8];
      s[i] = s[i] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      k[0] = k[0] ^ sbox[k[13]] ^ rc;
      k[1] = k[1] ^ sbox[k[14]];
      k[2] = k[2] ^ sbox[k[15]];
      k[3] = k[3] ^ sbox[k[12]];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- engine stub ----------------
  initial begin
    int           cnt;
    logic [127:0] key_cap, text_cap;
    cnt = 0;
    key_cap = '0;
    text_cap = '0;
    forever begin
      @(negedge clk);
      ifc.eng_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (busy) begin
            chk_w("eng_text_stable", ifc.eng_text, text_cap);
            chk_w("eng_key_stable", ifc.eng_key, key_cap);
          end
          ifc.eng_out  = aes_enc(key_cap, text_cap);
          ifc.eng_done = 1'b1;
        end
      end
      if (ifc.eng_start) begin
        if (ctr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL eng_start_unexpected: got start with text %h, required no start", ifc.eng_text);
        end else begin
          chk_w("eng_text", ifc.eng_text, ctr_q.pop_front());
          chk_w("eng_key", ifc.eng_key, m_key);
        end
        key_cap  = ifc.eng_key;
        text_cap = ifc.eng_text;
        text_log.push_back(ifc.eng_text);
        if (eng_en) cnt = int'($urandom_range(6, 12));
      end
    end
  end

  // ---------------- output monitor / out_ready driver ----------------
  initial begin
    bit           hold_p;
    logic [127:0] held_d;
    logic         held_l;
    hold_p = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_p && rst) begin
        chk_b("hold_valid", ifc.out_valid, 1'b1);
        chk_w("hold_data", ifc.out_data, held_d);
        chk_b("hold_last", ifc.out_last, held_l);
      end
      ifc.out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_d.size() == 0) begin
          tests++; fails++;
          $display("FAIL out_unexpected: got out_data %h, required no output", ifc.out_data);
        end else begin
          chk_w("out_data", ifc.out_data, exp_d.pop_front());
          chk_b("out_last", ifc.out_last, exp_l.pop_front());
        end
        got_q.push_back(ifc.out_data);
      end
      hold_p = rst && ifc.out_valid && !ifc.out_ready;
      held_d = ifc.out_data;
      held_l = ifc.out_last;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_cfg(input logic [127:0] key, input logic [127:0] iv);
    int k = 0;
    @(negedge clk);
    while (!ifc.cfg_ready && k < 200) begin @(negedge clk); k++; end
    chk_b("cfg_ready_wait", ifc.cfg_ready, 1'b1);
    ifc.cfg_valid = 1'b1;
    ifc.cfg_key   = key;
    ifc.cfg_iv    = iv;
    @(negedge clk);
    ifc.cfg_valid = 1'b0;
    m_key = key;
    m_ctr = iv;
  endtask

  // Returns in the START cycle of the accepted block
  task automatic send_blk(input logic [127:0] data, input logic last, input bit expect_out);
    int k = 0;
    while (!ifc.in_ready && k < 200) begin @(negedge clk); k++; end
    chk_b("in_ready_wait", ifc.in_ready, 1'b1);
    ifc.in_valid = 1'b1;
    ifc.in_data  = data;
    ifc.in_last  = last;
    ctr_q.push_back(m_ctr);
    if (expect_out) begin
      exp_d.push_back(data ^ aes_enc(m_key, m_ctr));
      exp_l.push_back(last);
      m_ctr = {m_ctr[127:32], m_ctr[31:0] + 32'd1};
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_d.size() != 0 || busy) && k < 500) begin @(negedge clk); k++; end
    chk_b("drain_idle", busy, 1'b0);
    chk_w("drain_pending", 128'(exp_d.size()), 128'(0));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key, iv, p0, p1, c0, c1;
    ifc.cfg_valid = 1'b0; ifc.cfg_key = '0; ifc.cfg_iv = '0;
    ifc.in_valid = 1'b0;  ifc.in_data = '0; ifc.in_last = 1'b0;
    ifc.eng_done = 1'b0;  ifc.eng_out = '0;
    ifc.out_ready = 1'b0;
    m_key = '0; m_ctr = '0;
    repeat (3) @(negedge clk);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_out_valid", ifc.out_valid, 1'b0);
    chk_b("rst_eng_start", ifc.eng_start, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_b("rst_cfg_ready", ifc.cfg_ready, 1'b1);
    chk_b("rst_in_ready", ifc.in_ready, 1'b0);
    chk_b("rst_err", err, 1'b0);
    chk_w("rst_blk_cnt", 128'(blk_cnt), 128'(0));
    chk_w("rst_eng_text", ifc.eng_text, 128'(0));

    // Single known-answer block
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    iv  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    got_q.delete(); text_log.delete();
    do_cfg(key, iv);
    send_blk(128'h6bc1bee22e409f96e93d7e117393172a, 1'b1, 1'b1);
    wait_idle();
    chk_w("kat1_out", got_q.size() > 0 ? got_q[0] : '0, 128'h874d6191b620e3261bef6864990db6ce);
    chk_w("kat1_blk_cnt", 128'(blk_cnt), 128'(1));
    chk_b("kat1_cfg_ready", ifc.cfg_ready, 1'b1);

    // Two-block known-answer stream
    got_q.delete(); text_log.delete();
    do_cfg(key, iv);
    send_blk(128'h6bc1bee22e409f96e93d7e117393172a, 1'b0, 1'b1);
    send_blk(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1, 1'b1);
    wait_idle();
    chk_w("kat2_out0", got_q.size() > 0 ? got_q[0] : '0, 128'h874d6191b620e3261bef6864990db6ce);
    chk_w("kat2_out1", got_q.size() > 1 ? got_q[1] : '0, 128'h9806f66b7970fdff8617187bb9fffdff);
    chk_w("kat2_text1", text_log.size() > 1 ? text_log[1] : '0, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);
    chk_w("kat2_blk_cnt", 128'(blk_cnt), 128'(2));

    // Counter wrap and decrypt round trip
    key = rnd128();
    iv  = {rnd128() >> 32, 32'hffffffff};
    p0  = rnd128();
    p1  = rnd128();
    got_q.delete(); text_log.delete();
    do_cfg(key, iv);
    send_blk(p0, 1'b0, 1'b1);
    send_blk(p1, 1'b1, 1'b1);
    wait_idle();
    chk_w("wrap_text1", text_log.size() > 1 ? text_log[1] : '0, {iv[127:32], 32'h0});
    c0 = got_q.size() > 0 ? got_q[0] : '0;
    c1 = got_q.size() > 1 ? got_q[1] : '0;
    got_q.delete();
    do_cfg(key, iv);
    send_blk(c0, 1'b0, 1'b1);
    send_blk(c1, 1'b1, 1'b1);
    wait_idle();
    chk_w("wrap_rt0", got_q.size() > 0 ? got_q[0] : '0, p0);
    chk_w("wrap_rt1", got_q.size() > 1 ? got_q[1] : '0, p1);

    // Randomized streams with gaps and random out_ready
    for (int s = 0; s < 6; s++) begin
      int n;
      n   = int'($urandom_range(1, 4));
      key = rnd128();
      iv  = rnd128();
      if (s % 2 == 1) iv[31:0] = 32'hfffffffe;
      do_cfg(key, iv);
      for (int b = 0; b < n; b++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_blk(rnd128(), (b == n - 1), 1'b1);
      end
      wait_idle();
      chk_w("rand_blk_cnt", 128'(blk_cnt), 128'(n));
    end

    // Backpressure: result held, no new block, no engine start
    bp_hold = 1'b1;
    do_cfg(rnd128(), rnd128());
    send_blk(rnd128(), 1'b1, 1'b1);
    begin
      int k = 0;
      while (!ifc.out_valid && k < 100) begin @(negedge clk); k++; end
    end
    chk_b("bp_valid_seen", ifc.out_valid, 1'b1);
    p0 = ifc.out_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_b("bp_valid", ifc.out_valid, 1'b1);
      chk_w("bp_data", ifc.out_data, p0);
      chk_b("bp_in_ready", ifc.in_ready, 1'b0);
      chk_b("bp_eng_start", ifc.eng_start, 1'b0);
    end
    bp_hold = 1'b0;
    wait_idle();

    // Engine timeout
    eng_en = 1'b0;
    do_cfg(rnd128(), rnd128());
    send_blk(rnd128(), 1'b1, 1'b0);
    repeat (TO) @(negedge clk);
    chk_b("to_err_early", err, 1'b0);
    chk_b("to_busy_early", busy, 1'b1);
    @(negedge clk);
    chk_b("to_err", err, 1'b1);
    chk_b("to_busy", busy, 1'b0);
    chk_b("to_cfg_ready", ifc.cfg_ready, 1'b1);
    chk_b("to_out_valid", ifc.out_valid, 1'b0);
    repeat (5) @(negedge clk);
    chk_b("to_err_sticky", err, 1'b1);
    eng_en = 1'b1;
    do_cfg(rnd128(), rnd128());
    chk_b("to_err_cleared", err, 1'b0);
    send_blk(rnd128(), 1'b1, 1'b1);
    wait_idle();

    // Reset in the middle of WAIT_ENG
    do_cfg(rnd128(), rnd128());
    send_blk(rnd128(), 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk_b("mid_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_b("mid_rst_busy", busy, 1'b0);
    chk_b("mid_rst_out_valid", ifc.out_valid, 1'b0);
    chk_b("mid_rst_in_ready", ifc.in_ready, 1'b0);
    chk_b("mid_rst_eng_start", ifc.eng_start, 1'b0);
    chk_b("mid_rst_err", err, 1'b0);
    chk_w("mid_rst_blk_cnt", 128'(blk_cnt), 128'(0));
    chk_w("mid_rst_eng_text", ifc.eng_text, 128'(0));
    chk_w("mid_rst_eng_key", ifc.eng_key, 128'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk_b("mid_post_out_valid", ifc.out_valid, 1'b0);
    chk_b("mid_post_cfg_ready", ifc.cfg_ready, 1'b1);
    chk_b("mid_post_busy", busy, 1'b0);

    repeat (5) @(negedge clk);
    chk_w("end_exp_empty", 128'(exp_d.size()), 128'(0));
    chk_w("end_ctr_empty", 128'(ctr_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
